data_mem_unit: RTL and testbench
================================

Name: data_mem_unit

Overview:
- Memory-side responder for the main control decoder's MemRead/MemWrite size codes: 0 = none, 1 = byte, 2 = half, 3 = word.
- Executes lb/lh/lw and sb/sh/sw against an internal word-organised synchronous RAM.
- Byte and halfword stores use read-modify-write. Loads are sign-extended. Byte order is big-endian.
- Sits between the ALU result (address) / register file (store data) and the writeback mux (MemtoReg path).

Parameters:
ADDR_W, 8, word-index width; RAM holds 2^ADDR_W 32-bit words.
INIT_ZERO, 1, when 1 the RAM is zero-filled by an initial block (simulation only); RAM is never cleared by reset.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  1  access request, sampled only while ready=1.
MemRead  input  2  load size code (0 none, 1 byte, 2 half, 3 word).
MemWrite  input  2  store size code (same encoding as MemRead).
addr  input  32  byte address; bits [ADDR_W+1:2] select the word, [1:0] select the lane, upper bits ignored.
wdata  input  32  store data; byte uses [7:0], half uses [15:0].
ready  output  1  high only in IDLE.
rdata  output  32  load result, sign-extended; held until the next completed access.
done  output  1  one-cycle completion pulse.
err  output  1  valid with done; high for illegal or misaligned requests.

Behaviour:
- Reset (async assert): state=IDLE; rdata=0, done=0, err=0. Reset aborts any in-flight access.
- Effect of reset mid-operation:
  - An in-flight RMW whose write edge has not occurred is not committed.
  - A word store is already committed at its accept edge.
- States: IDLE, RD, DONE.
- IDLE: ready=1, done=0. On an edge with req=1 the unit latches addr, wdata and the size codes. Transitions:
  - MemRead!=0 and MemWrite!=0 -> DONE, err=1, no RAM access.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) -> DONE, err=1, no RAM access.
  - Both codes 0 -> DONE, err=0, rdata unchanged.
  - Word store -> RAM written on this same edge -> DONE.
  - Load, or byte/half store -> RAM read issued -> RD.
- RD (one cycle; registered RAM word available):
  - Load: extract the lane and sign-extend into rdata at the exit edge.
    - Byte lanes: addr[1:0]=0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
    - Half lanes: addr[1]=0 -> [31:16], addr[1]=1 -> [15:0].
  - Store: merge wdata into the selected lane, leave other lanes unchanged, write the RAM at the exit edge.
  - Next state: DONE.
- DONE: done=1 for exactly one cycle, err valid; -> IDLE. Error and store completions leave rdata unchanged.
- Latency from the accept edge:
  - Word store, error and no-op: done high in the next cycle.
  - Load and byte/half store: done high in the second cycle after accept.
  - A new req can be accepted in the cycle after done.
- req while ready=0 is ignored, not queued. Inputs are don't-care after the accept edge.
- Address wrap: word index is taken modulo 2^ADDR_W, with no error.

Test Plan:
- Reset mid-RMW: sb 0xAA to addr 4 (word 0x01020304), assert rst_n=0 during RD -> no done, word still 0x01020304, rdata=0, ready=1 after release.
- Word store then byte loads: sw 0x11223344 @0x0 (done 1 cycle after accept), then:
  - lb @0x1 -> rdata 0x00000022, done 2 cycles after accept;
  - lb @0x3 -> 0x00000044.
- Sign extension:
  - sw 0x80FF7F00 @0x8, lb @0x8 -> 0xFFFFFF80;
  - lb @0xA -> 0x0000007F;
  - lh @0x8 -> 0xFFFF80FF.
- Partial stores:
  - Halfword: word @0x0 = 0x11223344, sh 0xBEEF @0x2 -> lw @0x0 = 0x1122BEEF.
  - Byte: sb 0x55 @0x0 -> lw @0x0 = 0x5522BEEF.
- Errors:
  - lw @0x6 -> done, err=1, rdata unchanged;
  - sh @0x1 -> err=1, memory unchanged;
  - MemRead=3 with MemWrite=3 -> err=1;
  - req during RD -> ignored, exactly one done.

Source files
------------

// File: rtl/data_mem_unit_if.sv
// ============================================================================
// Module      : data_mem_unit_if
// Description : Request/response bundle between the pipeline and the data
//               memory unit.
//               master (pipeline side) drives:
//                 req, MemRead, MemWrite, addr, wdata
//               slave (memory unit) drives:
//                 ready, rdata, done, err
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_mem_unit_if;
    logic        req;
    logic [1:0]  MemRead;
    logic [1:0]  MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        done;
    logic        err;

    modport master (
        output req, MemRead, MemWrite, addr, wdata,
        input  ready, rdata, done, err
    );

    modport slave (
        input  req, MemRead, MemWrite, addr, wdata,
        output ready, rdata, done, err
    );
endinterface

`default_nettype wire

// File: rtl/data_mem_unit.sv
// ============================================================================
// Module      : data_mem_unit
// Description : Memory-side responder for lb/lh/lw and sb/sh/sw.
//               Word-organised synchronous RAM, big-endian byte order.
//               Sub-word loads are sign-extended. Sub-word stores use
//               read-modify-write.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - data_mem_unit_if.slave:
//                         req/MemRead/MemWrite/addr/wdata in,
//                         ready/rdata/done/err out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_unit #(
    parameter int ADDR_W    = 8,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    data_mem_unit_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [31:0]         mem [DEPTH];

    logic [ADDR_W+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [1:0]          r_mrd;
    logic [1:0]          r_mwr;
    logic                r_err;
    logic [31:0]         r_rdata;
    logic [31:0]         r_word;

    // ------------------------------------------------------------------
    // Request decode (IDLE, from live inputs)
    // ------------------------------------------------------------------
    logic                w_accept;
    logic [1:0]          w_sz;
    logic                w_both;
    logic                w_misal;
    logic                w_bad;
    logic                w_noop;
    logic                w_wstore;

    always_comb begin
        w_accept = (r_state == S_IDLE) && bus.req;
        w_sz     = (bus.MemRead != 2'd0) ? bus.MemRead : bus.MemWrite;
        w_both   = (bus.MemRead != 2'd0) && (bus.MemWrite != 2'd0);
        w_misal  = ((w_sz == 2'd2) && bus.addr[0]) ||
                   ((w_sz == 2'd3) && (bus.addr[1:0] != 2'b00));
        w_bad    = w_both || w_misal;
        w_noop   = (w_sz == 2'd0);
        // A word store with a non-zero MemRead is already caught by w_bad.
        w_wstore = (bus.MemWrite == 2'd3) && !w_bad;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    if (w_bad || w_noop || w_wstore) w_next = S_DONE;
                    else                             w_next = S_RD;
                end
            end
            S_RD:    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Lane extract / merge (RD, from latched request and RAM word)
    // Big-endian: byte lane k sits at bit offset (3-k)*8, which is ~k*8.
    // ------------------------------------------------------------------
    logic [1:0]          w_lsz;
    logic [4:0]          w_shift;
    logic [31:0]         w_lane;
    logic [31:0]         w_load;
    logic [31:0]         w_mask;
    logic [31:0]         w_ins;
    logic [31:0]         w_merged;

    always_comb begin
        w_lsz   = (r_mrd != 2'd0) ? r_mrd : r_mwr;
        w_shift = 5'd0;
        w_mask  = 32'h0000_0000;
        w_ins   = 32'h0000_0000;
        w_load  = r_word;
        case (w_lsz)
            2'd1: begin
                w_shift = {~r_addr[1:0], 3'b000};
                w_mask  = 32'h0000_00FF << w_shift;
                w_ins   = (r_wdata & 32'h0000_00FF) << w_shift;
            end
            2'd2: begin
                w_shift = {~r_addr[1], 4'b0000};
                w_mask  = 32'h0000_FFFF << w_shift;
                w_ins   = (r_wdata & 32'h0000_FFFF) << w_shift;
            end
            default: ;
        endcase
        w_lane = r_word >> w_shift;
        case (w_lsz)
            2'd1:    w_load = {{24{w_lane[7]}},  w_lane[7:0]};
            2'd2:    w_load = {{16{w_lane[15]}}, w_lane[15:0]};
            default: w_load = r_word;
        endcase
        w_merged = (r_word & ~w_mask) | w_ins;
    end

    // ------------------------------------------------------------------
    // RAM port. The write enable is qualified by rst_n so that neither a
    // word store nor an RMW commit can land while reset is asserted.
    // ------------------------------------------------------------------
    logic                w_we;
    logic [ADDR_W-1:0]   w_widx;
    logic [31:0]         w_wd;

    always_comb begin
        w_we   = rst_n && ((w_accept && w_wstore) ||
                           ((r_state == S_RD) && (r_mwr != 2'd0)));
        w_widx = (r_state == S_IDLE) ? bus.addr[ADDR_W+1:2] : r_addr[ADDR_W+1:2];
        w_wd   = (r_state == S_IDLE) ? bus.wdata : w_merged;
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[w_widx] <= w_wd;
        end
        if (w_accept) begin
            r_word <= mem[w_widx];
        end
    end

    generate
        if (INIT_ZERO) begin : g_init_zero
            initial begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] = 32'h0000_0000;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control / result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= 32'h0000_0000;
            r_mrd   <= 2'd0;
            r_mwr   <= 2'd0;
            r_err   <= 1'b0;
            r_rdata <= 32'h0000_0000;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= bus.addr[ADDR_W+1:0];
                r_wdata <= bus.wdata;
                r_mrd   <= bus.MemRead;
                r_mwr   <= bus.MemWrite;
                r_err   <= w_bad;
            end
            if ((r_state == S_RD) && (r_mrd != 2'd0)) begin
                r_rdata <= w_load;
            end
        end
    end

    assign bus.ready = (r_state == S_IDLE);
    assign bus.done  = (r_state == S_DONE);
    assign bus.err   = r_err;
    assign bus.rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_unit.sv
// ============================================================================
// Module      : tb_data_mem_unit
// Description : Directed scoreboard bench for data_mem_unit. Stimulus pushes
//               the hand-computed response (rdata, err, completion cycle);
//               a monitor pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_unit;

    logic clk;
    logic rst_n;

    data_mem_unit_if bus ();

    data_mem_unit #(
        .ADDR_W    (8),
        .INIT_ZERO (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending done", cyc);
            end else begin
                mon_e = q.pop_front();
                check("rdata", bus.rdata, mon_e.rdata);
                check("err", {31'd0, bus.err}, {31'd0, mon_e.err});
                check("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // lat = number of cycles from accept edge until the cycle holding done.
    task automatic issue(input logic [1:0] rd, input logic [1:0] wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int lat, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=%b, required 1", bus.ready);
        end
        bus.req      = 1'b1;
        bus.MemRead  = rd;
        bus.MemWrite = wr;
        bus.addr     = a;
        bus.wdata    = wd;
        @(posedge clk);
        #1;
        if (push) q.push_back(exp_t'{exp_rd, exp_err, cyc + lat - 1});
        bus.req      = 1'b0;
        bus.MemRead  = 2'd0;
        bus.MemWrite = 2'd0;
        bus.addr     = 32'hDEAD_BEEF;
        bus.wdata    = 32'hCAFE_F00D;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses pending, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic acc(input logic [1:0] rd, input logic [1:0] wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat);
        issue(rd, wr, a, wd, exp_rd, exp_err, lat, 1'b1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.req      = 1'b0;
        bus.MemRead  = 2'd0;
        bus.MemWrite = 2'd0;
        bus.addr     = 32'h0;
        bus.wdata    = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, bus.ready}, 32'd1);
        check("reset_done",  {31'd0, bus.done},  32'd0);
        check("reset_err",   {31'd0, bus.err},   32'd0);
        check("reset_rdata", bus.rdata, 32'h0);
        rst_n = 1'b1;

        // Reset mid-RMW: prime rdata, then abort an sb during RD.
        acc(2'd0, 2'd3, 32'h4, 32'h0102_0304, 32'h0, 1'b0, 1);
        acc(2'd3, 2'd0, 32'h4, 32'h0,         32'h0102_0304, 1'b0, 2);
        issue(2'd0, 2'd1, 32'h4, 32'h0000_00AA, 32'h0, 1'b0, 2, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_rdata", bus.rdata, 32'h0);
        check("rst_mid_ready", {31'd0, bus.ready}, 32'd1);
        acc(2'd3, 2'd0, 32'h4, 32'h0, 32'h0102_0304, 1'b0, 2);

        // Word store then byte loads
        acc(2'd0, 2'd3, 32'h0, 32'h1122_3344, 32'h0102_0304, 1'b0, 1);
        acc(2'd1, 2'd0, 32'h1, 32'h0, 32'h0000_0022, 1'b0, 2);
        acc(2'd1, 2'd0, 32'h3, 32'h0, 32'h0000_0044, 1'b0, 2);

        // Sign extension
        acc(2'd0, 2'd3, 32'h8, 32'h80FF_7F00, 32'h0000_0044, 1'b0, 1);
        acc(2'd1, 2'd0, 32'h8, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
        acc(2'd1, 2'd0, 32'hA, 32'h0, 32'h0000_007F, 1'b0, 2);
        acc(2'd1, 2'd0, 32'h9, 32'h0, 32'hFFFF_FFFF, 1'b0, 2);
        acc(2'd2, 2'd0, 32'h8, 32'h0, 32'hFFFF_80FF, 1'b0, 2);
        acc(2'd2, 2'd0, 32'hA, 32'h0, 32'h0000_7F00, 1'b0, 2);

        // Partial stores
        acc(2'd0, 2'd2, 32'h2, 32'h0000_BEEF, 32'h0000_7F00, 1'b0, 2);
        acc(2'd3, 2'd0, 32'h0, 32'h0, 32'h1122_BEEF, 1'b0, 2);
        acc(2'd0, 2'd1, 32'h0, 32'h0000_0055, 32'h1122_BEEF, 1'b0, 2);
        acc(2'd3, 2'd0, 32'h0, 32'h0, 32'h5522_BEEF, 1'b0, 2);

        // Errors and no-op
        acc(2'd3, 2'd0, 32'h6, 32'h0,         32'h5522_BEEF, 1'b1, 1);
        acc(2'd0, 2'd2, 32'h1, 32'h0000_1234, 32'h5522_BEEF, 1'b1, 1);
        acc(2'd3, 2'd0, 32'h0, 32'h0,         32'h5522_BEEF, 1'b0, 2);
        acc(2'd3, 2'd3, 32'h0, 32'hFFFF_FFFF, 32'h5522_BEEF, 1'b1, 1);
        acc(2'd0, 2'd0, 32'h0, 32'h0,         32'h5522_BEEF, 1'b0, 1);
        acc(2'd3, 2'd0, 32'h0, 32'h0,         32'h5522_BEEF, 1'b0, 2);

        // Address wrap and ignored upper address bits
        acc(2'd3, 2'd0, 32'h0000_0400, 32'h0,         32'h5522_BEEF, 1'b0, 2);
        acc(2'd0, 2'd1, 32'hFFFF_F003, 32'h0000_0066, 32'h5522_BEEF, 1'b0, 2);
        acc(2'd3, 2'd0, 32'h0, 32'h0,                 32'h5522_BE66, 1'b0, 2);

        // req during RD is ignored: exactly one done
        issue(2'd1, 2'd0, 32'h0, 32'h0, 32'h0000_0055, 1'b0, 2, 1'b1);
        @(negedge clk);
        bus.req     = 1'b1;
        bus.MemRead = 2'd3;
        bus.addr    = 32'h4;
        @(negedge clk);
        bus.req     = 1'b0;
        bus.MemRead = 2'd0;
        drain();
        repeat (5) @(negedge clk);
        check("idle_after_ignored_req", {31'd0, bus.ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
